// File: rtl/dct_mac_unit.sv
// 1-D DCT multiply-accumulate unit: programmable N-entry coefficient bank, N-sample
// accumulation per block, round/saturate, and a valid/ready result register.
module dct_mac_unit #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 12,
    parameter int N      = 8,
    parameter int SHIFT  = 11,
    parameter int OUT_W  = 12,
    localparam int CNT_W = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     coef_we,
    input  logic [CNT_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + CNT_W;
    localparam logic signed [ACC_W:0] RND_C   = (SHIFT == 0) ? '0 : (ACC_W+1)'((2 ** SHIFT) / 2);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [CNT_W-1:0]      LAST    = CNT_W'(N - 1);

    // One extra bit of headroom so the rounding constant can never wrap the sum.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W:0] t;
        t = {s[ACC_W-1], s} + RND_C;
        return t >>> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (r < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic signed [COEF_W-1:0] coef_bank [N];
    logic signed [ACC_W-1:0]  acc_p0;
    logic [CNT_W-1:0]         cnt_p0;
    logic signed [OUT_W-1:0]  data_p1;
    logic                     sat_p1;
    logic                     vld_p1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic [OUT_W:0]           res;
    logic                     last;
    logic                     accept;
    logic                     load;
    logic                     addr_ok;

    assign prod     = PROD_W'(in_data) * PROD_W'(coef_bank[cnt_p0]);
    assign sum      = acc_p0 + {{CNT_W{prod[PROD_W-1]}}, prod};
    assign res      = saturate(round_shift(sum));
    assign last     = (cnt_p0 == LAST);
    assign in_ready = rst & ena & ~(last & vld_p1 & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign load     = accept & last;
    assign addr_ok  = 32'(coef_addr) < N;

    // Stage p0: coefficient bank; a write lands after this edge's product is formed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                coef_bank[i] <= '0;
        end else if (ena && coef_we && addr_ok) begin
            coef_bank[coef_addr] <= coef_wdata;
        end
    end

    // Stage p0: accumulator and sample index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
        end else if (accept) begin
            if (last) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
            end else begin
                acc_p0 <= sum;
                cnt_p0 <= cnt_p0 + 1'b1;
            end
        end
    end

    // Stage p1: result register with valid/ready handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_p1 <= '0;
            sat_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (ena) begin
            if (load) begin
                data_p1 <= res[OUT_W-1:0];
                sat_p1  <= res[OUT_W];
                vld_p1  <= 1'b1;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_sat   = sat_p1;
    assign out_valid = vld_p1;

endmodule

// File: doc/dct_mac_unit.md
# dct_mac_unit

Parametrised 1-D DCT multiply-accumulate unit for the `fdct_zigzag` path of `jpeg_encoder`. It is the next generation of the per-unit `coef` register stage in `dct_block`. It holds an N-entry programmable coefficient bank in enable flops, accumulates N signed sample×coefficient products per block, then rounds, saturates and presents one result through a valid/ready handshake. It replaces the fixed-width, fixed-coefficient, handshake-less units used today.

## Interface
Parameters:
- `DATA_W`, 8: signed sample width.
- `COEF_W`, 12: signed coefficient width.
- `N`, 8: products per block (≥2). `CNT_W = $clog2(N)`.
- `SHIFT`, 11: right shift applied to the accumulator before output (0 allowed).
- `OUT_W`, 12: signed output width.
- Derived: `ACC_W = DATA_W + COEF_W + CNT_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ena` in 1: global clock enable; low freezes all state.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in CNT_W: coefficient index.
- `coef_wdata` in COEF_W: signed coefficient.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accepted when `in_valid & in_ready`.
- `in_data` in DATA_W: signed sample.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer ready.
- `out_data` out OUT_W: signed rounded, saturated result.
- `out_sat` out 1: `out_data` was clipped.

## Operation
- Coefficient bank `coef[0..N-1]`:
  - Each entry is written at the clock edge when `ena & coef_we` and `coef_addr < N`. Writes to `coef_addr ≥ N` are ignored.
  - A write and a sample accept in the same cycle to the same index: the product uses the old value, and the new value applies from the next block.
- Sample index counter `cnt`, 0..N-1:
  - Accept: `prod = in_data * coef[cnt]`, full signed DATA_W+COEF_W width, sign-extended to ACC_W.
  - For `cnt < N-1`: `acc <= acc + prod`, `cnt <= cnt + 1`.
  - For `cnt == N-1`: the final sum `acc + prod` goes to the output stage, then `acc <= 0` and `cnt <= 0` (wrap).
- Output stage:
  - `r = (sum + 2^(SHIFT-1)) >>> SHIFT` (arithmetic shift, round half toward +inf). When SHIFT=0, `r = sum`.
  - If `r > 2^(OUT_W-1)-1`: output the max and set `out_sat=1`. If `r < -2^(OUT_W-1)`: output the min and set `out_sat=1`. Otherwise `out_sat=0`.
  - The rounding addition is performed at ACC_W+1 bits and never wraps.
- Output register: `out_data`, `out_sat` and `out_valid` are registered.
  - They hold stable while `out_valid & !out_ready`.
  - `out_valid` clears after a handshake unless a new result loads in the same cycle.
- `in_ready = ena & !(cnt == N-1 & out_valid & !out_ready)`. Only the final sample of a block is back-pressured.
- `ena` low:
  - No accept, no coefficient write, no output transfer.
  - `out_ready` is ignored and all registers hold.
  - `in_ready` is 0.
- Reset (`rst` low, any time, including mid-block):
  - `acc=0`, `cnt=0`, every `coef[i]=0`.
  - `out_data=0`, `out_sat=0`, `out_valid=0`.
  - A partial block is discarded. `in_ready` is 0 while `rst` is low and equals `ena` on the first cycle after release.

## Timing
- Throughput: 1 sample per cycle sustained, with back-to-back blocks and no bubble when `out_ready` is high.
- Latency: the final sample is accepted at edge T, and `out_valid`/`out_data` are visible after edge T.
- Simultaneous output drain and new result at the same edge: the new result loads and `out_valid` stays 1.
- Coefficient write at edge T affects samples accepted at edges after T.
- There are no combinational paths from `in_valid` or `in_data` to any output. `in_ready` depends combinationally on `out_ready` and `ena` only.
- The multiplier and adder complete in one cycle. No internal pipelining.

## Test plan
- **Basic sum.** N=8, SHIFT=0, OUT_W=16, all coefs=1, samples 1..8 with `out_ready=1` → one cycle after the 8th accept, `out_data=36`, `out_sat=0`, `out_valid` high for 1 cycle.
- **Saturation.** SHIFT=0, OUT_W=16, coefs=2047:
  - Samples 127×8 → `out_data=32767`, `out_sat=1`.
  - Samples −128×8 → `out_data=−32768`, `out_sat=1`.
- **Rounding.** SHIFT=2, coef[0]=6, others 0, sample[0]=1, rest 0 → `out_data=2`. Same with sample[0]=−1 → `out_data=−1`.
- **Backpressure.**
  - Hold `out_ready=0` while streaming 16 samples of two blocks: `in_ready` drops only while the 16th sample waits.
  - Raise `out_ready` → block 1 result drains, the 16th is accepted on the same edge, and the block 2 result appears the next cycle.
  - No sample is lost or duplicated.
- **Reset mid-block.**
  - After 3 accepted samples, pulse `rst` low asynchronously → `out_valid=0`, `out_data=0`, coefs read back as 0 (next block sums to 0).
  - Reload coefs=1 and feed 1..8 → `out_data=36`.
- **Coefficient write collision.** coef[3]=1. Write coef[3]=5 on the cycle sample index 3 (value 2) is accepted, other samples 0 → this block outputs 2, and the next identical block outputs 10.
